// File: rtl/seq_alu_mul.sv
// Registered ALU with logic, add/sub, shift, memory pass and an iterative shift-add multiply.
// Define SEQ_ALU_MUL_EARLY_EN to end the multiply once the remaining multiplier bits are all zero.
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcd,
    input  logic [WIDTH-1:0] inps,
    input  logic [WIDTH-1:0] inpt,
    input  logic [WIDTH-1:0] inpi,
    input  logic [WIDTH-1:0] inpm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aout,
    output logic             zflg,
    output logic             cflg
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    // Single-cycle ops; returns {carry, result}, carry nonzero only for add/sub.
    function automatic logic [WIDTH:0] alu_eval(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] xm;
        r  = '0;
        xm = x ^ {WIDTH{op[0]}};
        case (op[4:3])
            2'b00: begin
                case (op[1:0])
                    2'b00:   r[WIDTH-1:0] = s & x;
                    2'b01:   r[WIDTH-1:0] = s | x;
                    2'b10:   r[WIDTH-1:0] = s ^ x;
                    default: r[WIDTH-1:0] = ~s;
                endcase
            end
            2'b01: begin
                if (!op[1])
                    r = {1'b0, s} + {1'b0, xm} + (WIDTH+1)'(op[0]);
                else if (!op[0])
                    r[WIDTH-1:0] = s << x[SHW-1:0];
                else
                    r[WIDTH-1:0] = s >> x[SHW-1:0];
            end
            2'b10:   r[WIDTH-1:0] = m;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [0:0]         state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       cnt;
    logic               hisel;

    logic               accept;
    logic               is_mul_p0;
    logic [WIDTH-1:0]   x_p0;
    logic [WIDTH:0]     alu_p0;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_last;

    // Operand decode and single-cycle result, registered on the accepting edge
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul_p0 = (opcd[4:3] == 2'b11);
    assign x_p0      = opcd[2] ? inpi : inpt;
    assign alu_p0    = alu_eval(opcd, inps, x_p0, inpm);

    assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
    assign mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
    assign mul_res    = hisel ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

`ifdef SEQ_ALU_MUL_EARLY_EN
    assign mul_last = (cnt == CNT_LAST) || (mplier_nxt == '0);
`else
    assign mul_last = (cnt == CNT_LAST);
`endif

    // Result register and multiply iteration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            aout      <= '0;
            zflg      <= 1'b0;
            cflg      <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            hisel     <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mul_p0) begin
                        mcand  <= {{WIDTH{1'b0}}, inps};
                        mplier <= x_p0;
                        acc    <= '0;
                        cnt    <= '0;
                        hisel  <= opcd[0];
                        state  <= MUL;
                    end else begin
                        aout      <= alu_p0[WIDTH-1:0];
                        cflg      <= alu_p0[WIDTH];
                        zflg      <= (alu_p0[WIDTH-1:0] == '0);
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_nxt;
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= mplier_nxt;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    aout      <= mul_res;
                    cflg      <= 1'b0;
                    zflg      <= (mul_res == '0);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_mul.sv
// Directed bench for seq_alu_mul: WIDTH=8 by default, WIDTH=32 early-exit run under SEQ_ALU_MUL_EARLY_EN.
module tb_seq_alu_mul;

`ifdef SEQ_ALU_MUL_EARLY_EN
    localparam int W = 32;
`else
    localparam int W = 8;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcd;
    logic [W-1:0] inps, inpt, inpi, inpm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] aout;
    logic         zflg, cflg;

    int passed = 0;
    int total  = 0;

    seq_alu_mul #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .opcd(opcd),
        .inps(inps), .inpt(inpt), .inpi(inpi), .inpm(inpm),
        .out_valid(out_valid), .out_ready(out_ready),
        .aout(aout), .zflg(zflg), .cflg(cflg)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [4:0] op, input logic [W-1:0] s, input logic [W-1:0] t,
                         input logic [W-1:0] i, input logic [W-1:0] m);
        opcd = op; inps = s; inpt = t; inpi = i; inpm = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns cycles from acceptance to out_valid (1 = next cycle), -1 on timeout.
    task automatic wait_out(output int lat, output int busy);
        lat = 1; busy = 0;
        while (!out_valid && lat < 80) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcd = '0; inps = '0; inpt = '0; inpi = '0; inpm = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (aout !== '0) $display("FAIL rst_aout: got %h want 0", aout); else passed++;
        total++; if ({zflg, cflg} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {zflg, cflg}); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_logic;
        logic [4:0]   ops [5];
        logic [W-1:0] exp [5];
        int lat, busy;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110};
        exp = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'h0F};
        for (int k = 0; k < 5; k++) begin
            issue(ops[k], 8'hF0, 8'h3C, 8'hFF, 8'h00);
            wait_out(lat, busy);
            total++; if (aout !== exp[k]) $display("FAIL logic_%0d: got %h want %h", k, aout, exp[k]); else passed++;
            total++; if (lat !== 1) $display("FAIL logic_lat_%0d: got %0d want 1", k, lat); else passed++;
        end
    endtask

    task automatic test_addsub;
        int lat, busy;
        issue(5'b01001, 8'h05, 8'h07, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, cflg, zflg} !== {8'hFE, 2'b00}) $display("FAIL sub_5_7: got %h c%b z%b want fe c0 z0", aout, cflg, zflg); else passed++;
        total++; if (lat !== 1) $display("FAIL sub_lat: got %0d want 1", lat); else passed++;
        issue(5'b01001, 8'h07, 8'h05, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, cflg} !== {8'h02, 1'b1}) $display("FAIL sub_7_5: got %h c%b want 02 c1", aout, cflg); else passed++;
        issue(5'b01100, 8'hFF, 8'h00, 8'h01, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, cflg, zflg} !== {8'h00, 2'b11}) $display("FAIL add_wrap: got %h c%b z%b want 00 c1 z1", aout, cflg, zflg); else passed++;
        issue(5'b10000, 8'h11, 8'h22, 8'h33, 8'hA5);
        wait_out(lat, busy);
        total++; if ({aout, cflg} !== {8'hA5, 1'b0}) $display("FAIL mem_pass: got %h c%b want a5 c0", aout, cflg); else passed++;
    endtask

    task automatic test_shift;
        int lat, busy;
        issue(5'b01010, 8'h81, 8'h03, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if (aout !== 8'h08) $display("FAIL shl_3: got %h want 08", aout); else passed++;
        issue(5'b01111, 8'h81, 8'h00, 8'h01, 8'h00);
        wait_out(lat, busy);
        total++; if (aout !== 8'h40) $display("FAIL shr_imm1: got %h want 40", aout); else passed++;
        issue(5'b01010, 8'h5A, 8'h08, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if (aout !== 8'h5A) $display("FAIL shl_amt0: got %h want 5a", aout); else passed++;
    endtask

    task automatic test_mul;
        int lat, busy;
        issue(5'b11000, 8'hFF, 8'hFF, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if (aout !== 8'h01) $display("FAIL mul_lo: got %h want 01", aout); else passed++;
        total++; if (lat !== 9) $display("FAIL mul_lo_lat: got %0d want 9", lat); else passed++;
        total++; if (busy !== 8) $display("FAIL mul_busy: got %0d want 8", busy); else passed++;
        issue(5'b11001, 8'hFF, 8'hFF, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, cflg, zflg} !== {8'hFE, 2'b00}) $display("FAIL mul_hi: got %h c%b z%b want fe c0 z0", aout, cflg, zflg); else passed++;
        issue(5'b11000, 8'h37, 8'h00, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, zflg} !== {8'h00, 1'b1}) $display("FAIL mul_zero: got %h z%b want 00 z1", aout, zflg); else passed++;
        total++; if (lat !== 9) $display("FAIL mul_zero_lat: got %0d want 9", lat); else passed++;
        issue(5'b11101, 8'h10, 8'h00, 8'h20, 8'h00);
        wait_out(lat, busy);
        total++; if (aout !== 8'h02) $display("FAIL mul_imm_hi: got %h want 02", aout); else passed++;
    endtask

    task automatic test_back_to_back;
        int held = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(5'b00000, 8'hF0, 8'h3C, 8'h00, 8'h00);
        opcd = 5'b00001; in_valid = 1'b1;
        repeat (3) begin
            if (out_valid === 1'b1 && aout === 8'h30 && in_ready === 1'b0) held++;
            @(posedge clk); #1;
        end
        total++; if (held !== 3) $display("FAIL stall_hold: got %0d good cycles want 3", held); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if ({out_valid, aout} !== {1'b1, 8'hFC}) $display("FAIL b2b_second: got v%b %h want v1 fc", out_valid, aout); else passed++;
        opcd = 5'b00010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({out_valid, aout} !== {1'b1, 8'hCC}) $display("FAIL b2b_third: got v%b %h want v1 cc", out_valid, aout); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got v%b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid_mul;
        int lat, busy;
        int seen = 0;
        issue(5'b11000, 8'h12, 8'h34, 8'h00, 8'h00);
        repeat (3) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        total++; if ({out_valid, aout} !== {1'b0, 8'h00}) $display("FAIL midrst_out: got v%b %h want v0 00", out_valid, aout); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", in_ready); else passed++;
        #2 rstn = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midrst_ghost: got %0d valid cycles want 0", seen); else passed++;
        issue(5'b11000, 8'h03, 8'h05, 8'h00, 8'h00);
        wait_out(lat, busy);
        total++; if ({aout, lat} !== {8'h0F, 32'd9}) $display("FAIL midrst_next: got %h lat %0d want 0f lat 9", aout, lat); else passed++;
    endtask

    task automatic test_early;
        int lat, busy;
        issue(5'b11000, 32'd3, 32'd5, 32'd0, 32'd0);
        wait_out(lat, busy);
        total++; if (aout !== 32'd15) $display("FAIL early_3x5: got %h want 0000000f", aout); else passed++;
        total++; if (lat !== 4) $display("FAIL early_3x5_lat: got %0d want 4", lat); else passed++;
        issue(5'b11000, 32'd3, 32'd0, 32'd0, 32'd0);
        wait_out(lat, busy);
        total++; if ({aout, zflg} !== {32'd0, 1'b1}) $display("FAIL early_zero: got %h z%b want 0 z1", aout, zflg); else passed++;
        total++; if (lat !== 2) $display("FAIL early_zero_lat: got %0d want 2", lat); else passed++;
        issue(5'b11001, 32'd2, 32'h8000_0000, 32'd0, 32'd0);
        wait_out(lat, busy);
        total++; if (aout !== 32'd1) $display("FAIL early_full_hi: got %h want 00000001", aout); else passed++;
        total++; if (lat !== 33) $display("FAIL early_full_lat: got %0d want 33", lat); else passed++;
    endtask

    initial begin
        test_reset();
`ifdef SEQ_ALU_MUL_EARLY_EN
        test_early();
`else
        test_logic();
        test_addsub();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
